// File: rtl/vend_pkg.sv
// Shared definitions for the change-dispense sequencer: coin values,
// denomination indices, FSM state encoding and small helpers.
package vend_pkg;

  localparam int QUARTER = 25;
  localparam int DIME    = 10;
  localparam int NICKLE  = 5;

  // Width of the shared cycle timer; large enough for any count up to 255.
  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    DEN_Q = 2'd0,
    DEN_D = 2'd1,
    DEN_N = 2'd2
  } denom_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_WAIT   = 3'd3,
    S_GAP    = 3'd4,
    S_FINISH = 3'd5
  } seq_state_t;

  // Face value in cents of a denomination.
  function automatic int coin_value(input denom_t d);
    case (d)
      DEN_Q:   coin_value = QUARTER;
      DEN_D:   coin_value = DIME;
      default: coin_value = NICKLE;
    endcase
  endfunction

  // Position of a denomination in the {quarter,dime,nickle} bit vectors.
  function automatic logic [2:0] den_mask(input denom_t d);
    case (d)
      DEN_Q:   den_mask = 3'b100;
      DEN_D:   den_mask = 3'b010;
      default: den_mask = 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter with a zero flag. It stops at zero; a load always
// wins over counting.
module vend_timer
  import vend_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] count;

  // Count down towards zero, or restart from load_val.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/change_dispense_sequencer.sv
// Greedy coin-hopper payout sequencer. Accepts an amount over valid/ready,
// pulses quarter/dime/nickle hoppers one coin at a time, confirms each coin
// on the drop sensor, marks hoppers that time out as faulted and falls back
// to smaller coins, then strobes done with the unpaid remainder.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while idle, and a
// requester holding req_valid while busy simply waits.
module change_dispense_sequencer
  import vend_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic [2:0]       hop_empty,
  input  logic             coin_sense,
  output logic             outquarter,
  output logic             outdime,
  output logic             outnickle,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remainder,
  output logic [2:0]       hop_fault,
  output logic [2:0]       dbg_state
);

  seq_state_t       state, next_state;
  logic [AMT_W-1:0] bal;
  denom_t           sel, pick, sel_next;
  logic             found;
  logic             sense_pend;
  logic [2:0]       avail;
  logic [AMT_W-1:0] sel_val;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             ready_d, busy_d, done_d;
  logic [2:0]       drive_d;

  assign dbg_state = state;
  assign sel_val   = AMT_W'(coin_value(sel));

  // Largest usable denomination that still fits in the balance.
  always_comb begin
    avail = ~hop_empty & ~hop_fault;
    found = 1'b0;
    pick  = DEN_Q;
    if (avail[2] && bal >= AMT_W'(QUARTER)) begin
      found = 1'b1;
      pick  = DEN_Q;
    end else if (avail[1] && bal >= AMT_W'(DIME)) begin
      found = 1'b1;
      pick  = DEN_D;
    end else if (avail[0] && bal >= AMT_W'(NICKLE)) begin
      found = 1'b1;
      pick  = DEN_N;
    end
    sel_next = (state == S_SELECT) ? pick : sel;
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (req_valid) next_state = S_SELECT;
      S_SELECT: next_state = found ? S_PULSE : S_FINISH;
      S_PULSE:  if (tmr_zero) next_state = S_WAIT;
      S_WAIT: begin
        if (sense_pend || coin_sense) next_state = S_GAP;
        else if (tmr_zero)            next_state = S_SELECT;
      end
      S_GAP:    if (tmr_zero) next_state = S_SELECT;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Restart the shared timer on entry to each timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (next_state != state) begin
      case (next_state)
        S_PULSE: begin tmr_load = 1'b1; tmr_val = TMR_W'(PULSE_CYC - 1);   end
        S_WAIT:  begin tmr_load = 1'b1; tmr_val = TMR_W'(TIMEOUT_CYC - 1); end
        S_GAP:   begin tmr_load = 1'b1; tmr_val = TMR_W'(GAP_CYC - 1);     end
        default: ;
      endcase
    end
  end

  vend_timer u_timer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Balance, selected coin, early-sense capture and sticky hopper faults.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bal        <= '0;
      sel        <= DEN_Q;
      sense_pend <= 1'b0;
      hop_fault  <= 3'b000;
    end else begin
      if (state == S_IDLE && req_valid) bal <= req_amount;
      if (state == S_SELECT) begin
        sel        <= pick;
        sense_pend <= 1'b0;
      end else if (state == S_PULSE && coin_sense) begin
        sense_pend <= 1'b1;
      end
      if (state == S_WAIT) begin
        if (sense_pend || coin_sense) bal <= bal - sel_val;
        else if (tmr_zero)            hop_fault <= hop_fault | den_mask(sel);
      end
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    ready_d = (next_state == S_IDLE);
    busy_d  = (next_state != S_IDLE);
    done_d  = (next_state == S_FINISH);
    drive_d = (next_state == S_PULSE) ? den_mask(sel_next) : 3'b000;
  end

  // Output registers; remainder and short only change with done.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      outquarter <= 1'b0;
      outdime    <= 1'b0;
      outnickle  <= 1'b0;
      short      <= 1'b0;
      remainder  <= '0;
    end else begin
      req_ready  <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
      outquarter <= drive_d[2];
      outdime    <= drive_d[1];
      outnickle  <= drive_d[0];
      if (done_d) begin
        remainder <= bal;
        short     <= (bal >= AMT_W'(NICKLE));
      end
    end
  end

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Bench for change_dispense_sequencer: directed payout scenarios, a
// sensor responder, a greedy payout model and a per-cycle compare process.
module tb_change_dispense_sequencer;

  localparam int AMT_W     = 8;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 2;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic [2:0]       hop_empty = 3'b000;
  logic             coin_sense = 1'b0;
  logic             outquarter, outdime, outnickle;
  logic             busy, done, short;
  logic [AMT_W-1:0] remainder;
  logic [2:0]       hop_fault;
  logic [2:0]       dbg_state;

  change_dispense_sequencer #(
    .AMT_W(AMT_W), .PULSE_CYC(PULSE_CYC), .TIMEOUT_CYC(64), .GAP_CYC(GAP_CYC)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .hop_empty(hop_empty), .coin_sense(coin_sense),
    .outquarter(outquarter), .outdime(outdime), .outnickle(outnickle),
    .busy(busy), .done(done), .short(short), .remainder(remainder),
    .hop_fault(hop_fault), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state: expected drive vectors {q,d,n} in pulse order.
  logic [2:0] exp_q[$];
  logic       sense_q[$];
  int         exp_rem;
  logic       exp_short;
  logic [2:0] m_fault = 3'b000;

  logic       txn_open = 1'b0;
  int         cyc_n = 0;
  int         pulses_seen = 0;
  int         last_rem = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Greedy payout model: pick the largest usable coin that fits; a coin
  // whose plan bit is 0 never drops, so its hopper becomes faulted.
  task automatic model_txn(input int amount, input logic [2:0] empty, input logic [15:0] plan);
    int  bal;
    int  k;
    bit  found;
    int  vals[3];
    vals = '{25, 10, 5};
    bal  = amount;
    k    = 0;
    exp_q.delete();
    do begin
      found = 0;
      for (int j = 0; j < 3; j++) begin
        if (!found && !empty[2-j] && !m_fault[2-j] && bal >= vals[j]) begin
          found = 1;
          exp_q.push_back(3'b100 >> j);
          if (k > 15 || plan[k]) bal = bal - vals[j];
          else                   m_fault[2-j] = 1'b1;
          k++;
        end
      end
    end while (found);
    exp_rem   = bal;
    exp_short = (bal >= 5);
  endtask

  // Sensor responder: one cycle after a drive line falls, pulse coin_sense
  // for one cycle unless the plan says this coin never drops.
  logic [2:0] rsp_prev = 3'b000;
  int         rsp_delay = 0;
  always @(negedge CLK) begin
    logic [2:0] drv;
    logic       drop;
    drv = {outquarter, outdime, outnickle};
    coin_sense <= 1'b0;
    if (!RESET_N) begin
      rsp_delay = 0;
    end else begin
      if (rsp_delay == 1) coin_sense <= 1'b1;
      if (rsp_delay > 0) rsp_delay--;
      if (drv == 3'b000 && rsp_prev != 3'b000) begin
        drop = (sense_q.size() == 0) ? 1'b1 : sense_q.pop_front();
        if (drop) rsp_delay = 1;
      end
    end
    rsp_prev = drv;
  end

  // Compare process: checks the outputs every cycle against the model.
  logic [2:0] mon_prev = 3'b000;
  logic [2:0] mon_cur  = 3'b000;
  int         mon_width = 0;
  int         idle_run  = 0;
  always @(negedge CLK) begin
    logic [2:0] drv;
    drv = {outquarter, outdime, outnickle};
    if (!RESET_N) begin
      mon_prev  = 3'b000;
      mon_width = 0;
    end else begin
      check("onehot_drive", ($countones(drv) <= 1), 1);
      check("busy_vs_ready", busy, !req_ready);
      if (txn_open) begin
        if (cyc_n == 0) begin
          check("busy_after_accept", busy, 1);
          check("ready_after_accept", req_ready, 0);
        end
        if (cyc_n == 1) begin
          if (exp_q.size() != 0) check("first_pulse_cycle2", drv, exp_q[0]);
          else                   check("done_cycle2", done, 1);
        end
        cyc_n++;
      end
      if (drv != 3'b000) begin
        if (mon_prev == 3'b000) begin
          if (txn_open && pulses_seen > 0) check("gap_idle", (idle_run >= GAP_CYC), 1);
          mon_cur   = drv;
          mon_width = 1;
        end else begin
          check("drive_stable", drv, mon_prev);
          mon_width++;
        end
        idle_run = 0;
      end else begin
        idle_run++;
        if (mon_prev != 3'b000 && txn_open) begin
          check("pulse_width", mon_width, PULSE_CYC);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", mon_cur, 0);
          end else begin
            check("pulse_denom", mon_cur, exp_q.pop_front());
          end
          pulses_seen++;
        end
      end
      if (done) begin
        if (!txn_open) begin
          check("unexpected_done", done, 0);
        end else begin
          check("remainder", remainder, exp_rem);
          check("short", short, exp_short);
          check("hop_fault", hop_fault, m_fault);
          check("pulses_left", exp_q.size(), 0);
          check("no_drive_at_done", drv, 0);
          last_rem = remainder;
          txn_open = 1'b0;
        end
      end
      mon_prev = drv;
    end
  end

  // Driver: present one request, wait for done, then check the literal
  // hand-computed pulse count and remainder.
  task automatic run_txn(input string name, input int amount, input logic [2:0] empty,
                         input logic [15:0] plan, input int lit_pulses, input int lit_rem);
    bit ok;
    model_txn(amount, empty, plan);
    sense_q.delete();
    for (int k = 0; k < 16; k++) sense_q.push_back(plan[k]);
    hop_empty = empty;
    @(negedge CLK);
    check({name, "_ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_amount = AMT_W'(amount);
    @(posedge CLK);
    #1;
    req_valid   = 1'b0;
    cyc_n       = 0;
    pulses_seen = 0;
    idle_run    = 0;
    txn_open    = 1'b1;
    ok = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge CLK);
      #2;
      if (!txn_open) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 1000 cycles", name);
      txn_open = 1'b0;
    end
    check({name, "_pulses"}, pulses_seen, lit_pulses);
    check({name, "_rem"}, last_rem, lit_rem);
    sense_q.delete();
  endtask

  // Pulse reset while a drive line is high and check the async drop.
  task automatic reset_mid_pulse(input int amount, input string name);
    hop_empty = 3'b000;
    @(negedge CLK);
    req_valid  = 1'b1;
    req_amount = AMT_W'(amount);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check({name, "_drive_up"}, {outquarter, outdime, outnickle} != 3'b000, 1);
    #1;
    RESET_N = 1'b0;
    #1;
    check({name, "_drive_async_low"}, {outquarter, outdime, outnickle}, 0);
    check({name, "_fault_clear"}, hop_fault, 0);
    check({name, "_busy_low"}, busy, 0);
    m_fault = 3'b000;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check({name, "_ready_after_release"}, req_ready, 1);
    check({name, "_state_idle"}, busy, 0);
  endtask

  initial begin
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drive", {outquarter, outdime, outnickle}, 0);
    check("rst_remainder", remainder, 0);
    check("rst_short", short, 0);
    check("rst_fault", hop_fault, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    run_txn("pay40",   40,  3'b000, 16'hFFFF, 3, 0);
    run_txn("pay30_qe", 30, 3'b100, 16'hFFFF, 3, 0);
    run_txn("pay15_dn_e", 15, 3'b011, 16'hFFFF, 0, 15);
    run_txn("pay7",    7,   3'b000, 16'hFFFF, 1, 2);
    run_txn("pay0",    0,   3'b000, 16'hFFFF, 0, 0);
    run_txn("pay3",    3,   3'b000, 16'hFFFF, 0, 3);
    run_txn("pay255",  255, 3'b000, 16'hFFFF, 11, 0);
    reset_mid_pulse(25, "rst_q");
    run_txn("pay25_qfault", 25, 3'b000, 16'hFFFE, 4, 0);
    check("qfault_literal", hop_fault, 3'b100);
    run_txn("pay25_skipq", 25, 3'b000, 16'hFFFF, 3, 0);
    run_txn("pay35_nq_dn", 35, 3'b001, 16'hFFFF, 3, 5);
    reset_mid_pulse(10, "rst_d");
    run_txn("pay25_after_rst", 25, 3'b000, 16'hFFFF, 1, 0);

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
